// File: rtl/serial_full_sub.sv
// serial_full_sub: bit-serial N-bit subtractor, d = a - b - bin, LSB first.
// One full-subtractor cell is reused across N clocks; an op takes N cycles
// in RUN followed by a single DONE cycle that carries the done pulse.
// Optional feature macro: SERIAL_SUB_OVF_EN adds the signed-overflow port ovf.
// Handshake: start is sampled on a rising edge only while idle (IDLE or DONE);
// a sampled start captures a/b/bin. busy is high for exactly the N RUN cycles,
// done is high for the one cycle after, and d/bout (and ovf) stay valid from
// done until the next accepted start. start seen during RUN is ignored.
module serial_full_sub #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] d,
    output logic         bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          load;

    logic [N-1:0]  sa;
    logic [N-1:0]  sb;
    logic          br;
    logic [CW-1:0] count;

    logic          diff;
    logic          borrow;
    logic          last_bit;

    // Full-subtractor cell on the current LSBs plus the running borrow.
    always_comb begin
        diff     = sa[0] ^ sb[0] ^ br;
        borrow   = (~sa[0] & sb[0]) | (~sa[0] & br) | (sb[0] & br);
        last_bit = (count == LAST);
    end

    // Next-state logic; load marks an accepted start (IDLE or DONE only).
    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Registered status outputs, decoded from the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next == RUN);
            done <= (state_next == DONE);
        end
    end

    // Operand shifters, borrow chain, bit counter and result shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa    <= '0;
            sb    <= '0;
            br    <= 1'b0;
            count <= '0;
            d     <= '0;
            bout  <= 1'b0;
        end else if (load) begin
            sa    <= a;
            sb    <= b;
            br    <= bin;
            count <= '0;
            d     <= '0;
            bout  <= 1'b0;
        end else if (state == RUN) begin
            d  <= {diff, d[N-1:1]};
            sa <= {1'b0, sa[N-1:1]};
            sb <= {1'b0, sb[N-1:1]};
            br <= borrow;
            if (last_bit) begin
                // Borrow out of the MSB; count parks at N-1 until next load.
                bout <= borrow;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic br_msb_in;

    // Borrow into the MSB, captured on the final bit and held with d.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_msb_in <= 1'b0;
        end else if (load) begin
            br_msb_in <= 1'b0;
        end else if ((state == RUN) && last_bit) begin
            br_msb_in <= br;
        end
    end

    // Signed overflow: borrow into the MSB differs from borrow out of it.
    // Both terms are flops that clear together on reset and on load.
    assign ovf = br_msb_in ^ bout;
`endif

endmodule

// File: tb/tb_serial_full_sub.sv
// tb_serial_full_sub: directed and randomized checks of serial_full_sub
// against an arithmetic reference model and an expected-result queue.
module tb_serial_full_sub;

    localparam int N = 8;
    localparam int W = N + 2;  // {ovf, bout, d}

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [N-1:0] d;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    always #5 clk = ~clk;

    serial_full_sub #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     tag, got, got, exp, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic logic [W-1:0] ref_sub(input logic [N-1:0] x, input logic [N-1:0] y,
                                             input logic c);
        int ux, uy, uc, diff, sx, sy, sdiff;
        logic [N-1:0] dd;
        logic bo, ov;
        ux    = 32'(x);
        uy    = 32'(y);
        uc    = 32'(c);
        diff  = ux - uy - uc;
        dd    = diff[N-1:0];
        bo    = (ux < uy + uc);
        sx    = 32'($signed(x));
        sy    = 32'($signed(y));
        sdiff = sx - sy - uc;
        ov    = (sdiff < -(1 << (N - 1))) || (sdiff > (1 << (N - 1)) - 1);
        return {ov, bo, dd};
    endfunction

    // Pop the oldest expected result and compare against the DUT outputs.
    task automatic sb_check(input string tag);
        logic [W-1:0] e;
        check({tag, "_exp_avail"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_d"}, 32'(d), 32'(e[N-1:0]));
            check({tag, "_bout"}, 32'(bout), 32'(e[N]));
`ifdef SERIAL_SUB_OVF_EN
            check({tag, "_ovf"}, 32'(ovf), 32'(e[N+1]));
`endif
        end
    endtask

    // ---------------- driver tasks ----------------
    // One op: pulse start, then during RUN scramble a/b/bin and optionally
    // pulse start (poke = cycle index forcing start with a=1,b=1; -1 = random).
    task automatic do_op(input string tag, input logic [N-1:0] ta, input logic [N-1:0] tb,
                         input logic tbin, input int poke);
        int  busy_cyc;
        int  both_hi;
        bit  seen;
        logic [N-1:0] held_d;
        exp_q.push_back(ref_sub(ta, tb, tbin));
        @(negedge clk);
        start = 1'b1;
        a     = ta;
        b     = tb;
        bin   = tbin;
        @(negedge clk);
        start    = 1'b0;
        busy_cyc = 0;
        both_hi  = 0;
        seen     = 1'b0;
        for (int i = 0; i < N + 4 && !seen; i++) begin
            if (busy && done) both_hi++;
            if (done) begin
                seen  = 1'b1;
                start = 1'b0;
            end else begin
                if (busy) begin
                    busy_cyc++;
                    if (poke < 0) begin
                        start = 1'($urandom_range(0, 1));
                        a     = N'($urandom);
                        b     = N'($urandom);
                        bin   = 1'($urandom_range(0, 1));
                    end else if (i == poke) begin
                        start = 1'b1;
                        a     = N'(1);
                        b     = N'(1);
                        bin   = 1'b0;
                    end else begin
                        start = 1'b0;
                    end
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(N));
        check({tag, "_busy_done_overlap"}, 32'(both_hi), 32'd0);
        if (seen) begin
            held_d = d;
            sb_check(tag);
            @(negedge clk);
            check({tag, "_done_pulse_len"}, 32'(done), 32'd0);
            check({tag, "_d_hold"}, 32'(d), 32'(held_d));
            check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        end else begin
            exp_q.delete();
        end
    endtask

    // ---------------- stimulus ----------------
    logic [N-1:0] bb_a[3];
    logic [N-1:0] bb_b[3];

    initial begin
        int  issued, dones, cyc, last_done, saw;
        bit  prev_busy;
        logic [N-1:0] ra, rb;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_d", 32'(d), 32'd0);
        check("reset_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("reset_ovf", 32'(ovf), 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed operand patterns, including boundaries.
        do_op("op_100_37", N'(100), N'(37), 1'b0, -2);
        do_op("op_5_10", N'(5), N'(10), 1'b0, -2);
        do_op("op_0_0_bin", N'(0), N'(0), 1'b1, -2);
        do_op("op_255_255_bin", N'(255), N'(255), 1'b1, -2);
        do_op("op_0_255", N'(0), N'(255), 1'b0, -2);
        do_op("op_255_0_bin", N'(255), N'(0), 1'b1, -2);
        do_op("op_80_01", N'(8'h80), N'(8'h01), 1'b0, -2);
        do_op("op_10_01", N'(8'h10), N'(8'h01), 1'b0, -2);
        do_op("op_7f_ff", N'(8'h7F), N'(8'hFF), 1'b0, -2);

        // start pulsed during RUN with a=1,b=1 must be ignored.
        do_op("poke_run", N'(100), N'(37), 1'b0, 3);

        // Back-to-back ops with start held high.
        bb_a[0] = N'(10);  bb_b[0] = N'(3);
        bb_a[1] = N'(200); bb_b[1] = N'(1);
        bb_a[2] = N'(7);   bb_b[2] = N'(7);
        @(negedge clk);
        start = 1'b1;
        a     = bb_a[0];
        b     = bb_b[0];
        bin   = 1'b0;
        exp_q.push_back(ref_sub(bb_a[0], bb_b[0], 1'b0));
        issued    = 1;
        dones     = 0;
        cyc       = 0;
        last_done = -1;
        prev_busy = 1'b0;
        for (int i = 0; i < 3 * (N + 1) + 6 && dones < 3; i++) begin
            @(negedge clk);
            cyc++;
            if (busy && !prev_busy && issued < 3) begin
                a = bb_a[issued];
                b = bb_b[issued];
                exp_q.push_back(ref_sub(bb_a[issued], bb_b[issued], 1'b0));
                issued++;
            end
            if (done) begin
                sb_check("b2b");
                if (last_done >= 0) check("b2b_spacing", 32'(cyc - last_done), 32'(N + 1));
                last_done = cyc;
                dones++;
                if (dones == 3) start = 1'b0;
            end
            prev_busy = busy;
        end
        start = 1'b0;
        check("b2b_done_count", 32'(dones), 32'd3);
        check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clk);
        check("b2b_idle_busy", 32'(busy), 32'd0);

        // Reset in the middle of RUN: outputs clear at once, no done follows.
        @(negedge clk);
        start = 1'b1;
        a     = N'(100);
        b     = N'(37);
        bin   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid_busy_before", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        check("rst_mid_d", 32'(d), 32'd0);
        check("rst_mid_bout", 32'(bout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        saw = 0;
        for (int i = 0; i < N + 3; i++) begin
            @(negedge clk);
            if (done || busy) saw++;
        end
        check("rst_mid_no_done", 32'(saw), 32'd0);
        do_op("after_rst", N'(100), N'(37), 1'b0, -2);

        // Randomized ops with noisy inputs during RUN and idle gaps.
        for (int k = 0; k < 40; k++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            do_op("rand", ra, rb, 1'($urandom_range(0, 1)), -1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Watchdog: the run must never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, got %0d checks, expected completion",
                 n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
